// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the programmable video timing generator.
// Timing sets are stored in fixed-width fields wide enough for any mode.
package video_timing_pkg;

  localparam int TW = 16;

  typedef struct packed {
    logic [TW-1:0] h_visible;
    logic [TW-1:0] h_front;
    logic [TW-1:0] h_sync;
    logic [TW-1:0] h_back;
    logic [TW-1:0] v_visible;
    logic [TW-1:0] v_front;
    logic [TW-1:0] v_sync;
    logic [TW-1:0] v_back;
    logic          hpol;
    logic          vpol;
  } timing_cfg_t;

  localparam timing_cfg_t VGA_640X480 = '{
    h_visible: 16'd640, h_front: 16'd16,
    h_sync:    16'd96,  h_back:  16'd48,
    v_visible: 16'd480, v_front: 16'd10,
    v_sync:    16'd2,   v_back:  16'd33,
    hpol:      1'b0,    vpol:    1'b0
  };

  // A mode is usable when no field is zero and both totals fit
  // in the counter widths; totals are summed two bits wider.
  function automatic logic cfg_ok(timing_cfg_t c, int hw, int vw);
    logic [TW+1:0] hs;
    logic [TW+1:0] vs;
    logic          nz;
    hs = {2'b00, c.h_visible} + {2'b00, c.h_front}
       + {2'b00, c.h_sync}    + {2'b00, c.h_back};
    vs = {2'b00, c.v_visible} + {2'b00, c.v_front}
       + {2'b00, c.v_sync}    + {2'b00, c.v_back};
    nz = (|c.h_visible) && (|c.h_front)
      && (|c.h_sync)    && (|c.h_back)
      && (|c.v_visible) && (|c.v_front)
      && (|c.v_sync)    && (|c.v_back);
    return nz
      && (hs < ((TW+2)'(1) << hw))
      && (vs < ((TW+2)'(1) << vw));
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register that lines timing outputs up with a
// downstream pixel pipeline; DEPTH of zero is a plain wire.
module video_delay_line #(
  parameter int             W       = 8,
  parameter int             DEPTH   = 0,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign q_o = d_i;
  end else begin : g_pipe
    logic [W-1:0] stg_q [DEPTH];

    // Shift one stage per clock; reset loads the idle output level.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) stg_q[i] <= RST_VAL;
      end else begin
        stg_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stg_q[i] <= stg_q[i-1];
      end
    end

    assign q_o = stg_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Runtime-programmable raster timing generator with a shadowed config
// that only takes effect at the frame boundary.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_W           = 12,
  parameter int V_W           = 11,
  parameter int FRAME_W       = 32,
  parameter int DELAY         = 0,
  parameter int DEF_H_VISIBLE = int'(VGA_640X480.h_visible),
  parameter int DEF_H_FRONT   = int'(VGA_640X480.h_front),
  parameter int DEF_H_SYNC    = int'(VGA_640X480.h_sync),
  parameter int DEF_H_BACK    = int'(VGA_640X480.h_back),
  parameter int DEF_V_VISIBLE = int'(VGA_640X480.v_visible),
  parameter int DEF_V_FRONT   = int'(VGA_640X480.v_front),
  parameter int DEF_V_SYNC    = int'(VGA_640X480.v_sync),
  parameter int DEF_V_BACK    = int'(VGA_640X480.v_back),
  parameter bit DEF_HPOL      = VGA_640X480.hpol,
  parameter bit DEF_VPOL      = VGA_640X480.vpol
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [H_W-1:0]     cfg_h_visible,
  input  logic [H_W-1:0]     cfg_h_front,
  input  logic [H_W-1:0]     cfg_h_sync,
  input  logic [H_W-1:0]     cfg_h_back,
  input  logic [V_W-1:0]     cfg_v_visible,
  input  logic [V_W-1:0]     cfg_v_front,
  input  logic [V_W-1:0]     cfg_v_sync,
  input  logic [V_W-1:0]     cfg_v_back,
  input  logic               cfg_hpol,
  input  logic               cfg_vpol,
  input  logic               cfg_valid,
  output logic               cfg_error,
  output logic               cfg_pending,
  output logic               cfg_applied,
  output logic               hsync,
  output logic               vsync,
  output logic               visible,
  output logic [H_W-1:0]     position_x,
  output logic [V_W-1:0]     position_y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame
);

  localparam timing_cfg_t DEF_CFG = '{
    h_visible: TW'(DEF_H_VISIBLE), h_front: TW'(DEF_H_FRONT),
    h_sync:    TW'(DEF_H_SYNC),    h_back:  TW'(DEF_H_BACK),
    v_visible: TW'(DEF_V_VISIBLE), v_front: TW'(DEF_V_FRONT),
    v_sync:    TW'(DEF_V_SYNC),    v_back:  TW'(DEF_V_BACK),
    hpol:      DEF_HPOL,           vpol:    DEF_VPOL
  };

  localparam int DW = 5 + H_W + V_W + FRAME_W;
  localparam logic [DW-1:0] RST_VAL =
    {~DEF_HPOL, ~DEF_VPOL, {(DW-2){1'b0}}};

  timing_cfg_t        act_q, act_d;
  timing_cfg_t        shd_q, shd_d;
  timing_cfg_t        req;
  logic               pend_q, pend_d;
  logic               err_q, err_d;
  logic [H_W-1:0]     h_q, h_d;
  logic [V_W-1:0]     v_q, v_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  logic [TW-1:0] hx, vy, ht, vt;
  logic [TW-1:0] hs_beg, hs_end, vs_beg, vs_end;
  logic          h_last, v_last, apply;
  logic          vis_c, hs_c, vs_c, ls_c, fs_c;
  logic [H_W-1:0] px_c;
  logic [V_W-1:0] py_c;
  logic [DW-1:0]  dl_d, dl_q;

  assign req = '{
    h_visible: TW'(cfg_h_visible), h_front: TW'(cfg_h_front),
    h_sync:    TW'(cfg_h_sync),    h_back:  TW'(cfg_h_back),
    v_visible: TW'(cfg_v_visible), v_front: TW'(cfg_v_front),
    v_sync:    TW'(cfg_v_sync),    v_back:  TW'(cfg_v_back),
    hpol:      cfg_hpol,           vpol:    cfg_vpol
  };

  assign hx     = TW'(h_q);
  assign vy     = TW'(v_q);
  assign hs_beg = act_q.h_visible + act_q.h_front;
  assign hs_end = hs_beg + act_q.h_sync;
  assign ht     = hs_end + act_q.h_back;
  assign vs_beg = act_q.v_visible + act_q.v_front;
  assign vs_end = vs_beg + act_q.v_sync;
  assign vt     = vs_end + act_q.v_back;

  assign h_last = hx == ht - TW'(1);
  assign v_last = vy == vt - TW'(1);
  assign apply  = h_last && v_last && pend_q;

  assign vis_c = (hx < act_q.h_visible) && (vy < act_q.v_visible);
  assign hs_c  = ((hx >= hs_beg) && (hx < hs_end)) ^ ~act_q.hpol;
  assign vs_c  = ((vy >= vs_beg) && (vy < vs_end)) ^ ~act_q.vpol;
  assign ls_c  = (h_q == '0) && (vy < act_q.v_visible);
  assign fs_c  = (h_q == '0) && (v_q == '0);
  assign px_c  = vis_c ? h_q : '0;
  assign py_c  = vis_c ? v_q : '0;

  // Raster advance, frame count, shadow load and boundary apply.
  always_comb begin
    h_d     = h_q + H_W'(1);
    v_d     = v_q;
    frame_d = frame_q;
    act_d   = act_q;
    shd_d   = shd_q;
    pend_d  = pend_q;
    err_d   = 1'b0;
    if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + V_W'(1);
    end
    if (h_last && v_last) frame_d = frame_q + FRAME_W'(1);
    if (apply) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    if (cfg_valid) begin
      if (cfg_ok(req, H_W, V_W)) begin
        shd_d  = req;
        pend_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers; reset restarts the raster under the default mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
      act_q   <= DEF_CFG;
      shd_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign cfg_error   = err_q;
  assign cfg_pending = pend_q;
  assign cfg_applied = apply;

  assign dl_d = {hs_c, vs_c, vis_c, px_c, py_c, ls_c, fs_c, frame_q};

  video_delay_line #(
    .W      (DW),
    .DEPTH  (DELAY),
    .RST_VAL(RST_VAL)
  ) u_dly (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (dl_d),
    .q_o  (dl_q)
  );

  assign {hsync, vsync, visible, position_x, position_y,
          line_start, frame_start, frame} = dl_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: small 15x8 default mode,
// a DELAY=0 and a DELAY=3 instance sharing clock, reset and config.
module tb_video_timing_gen;

  localparam int H_W = 12;
  localparam int V_W = 11;
  localparam int FW  = 32;
  localparam int NR  = 250;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [H_W-1:0] chv, chf, chs, chb;
  logic [V_W-1:0] cvv, cvf, cvs, cvb;
  logic           chp, cvp, cval;

  logic           err0, pend0, appl0, hs0, vs0, vis0, ls0, fs0;
  logic [H_W-1:0] x0;
  logic [V_W-1:0] y0;
  logic [FW-1:0]  fr0;

  logic           err3, pend3, appl3, hs3, vs3, vis3, ls3, fs3;
  logic [H_W-1:0] x3;
  logic [V_W-1:0] y3;
  logic [FW-1:0]  fr3;

  video_timing_gen #(
    .H_W(H_W), .V_W(V_W), .FRAME_W(FW), .DELAY(0),
    .DEF_H_VISIBLE(8), .DEF_H_FRONT(2), .DEF_H_SYNC(3), .DEF_H_BACK(2),
    .DEF_V_VISIBLE(4), .DEF_V_FRONT(1), .DEF_V_SYNC(2), .DEF_V_BACK(1),
    .DEF_HPOL(1'b0), .DEF_VPOL(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .cfg_h_visible(chv), .cfg_h_front(chf),
    .cfg_h_sync(chs), .cfg_h_back(chb),
    .cfg_v_visible(cvv), .cfg_v_front(cvf),
    .cfg_v_sync(cvs), .cfg_v_back(cvb),
    .cfg_hpol(chp), .cfg_vpol(cvp), .cfg_valid(cval),
    .cfg_error(err0), .cfg_pending(pend0), .cfg_applied(appl0),
    .hsync(hs0), .vsync(vs0), .visible(vis0),
    .position_x(x0), .position_y(y0),
    .line_start(ls0), .frame_start(fs0), .frame(fr0)
  );

  video_timing_gen #(
    .H_W(H_W), .V_W(V_W), .FRAME_W(FW), .DELAY(3),
    .DEF_H_VISIBLE(8), .DEF_H_FRONT(2), .DEF_H_SYNC(3), .DEF_H_BACK(2),
    .DEF_V_VISIBLE(4), .DEF_V_FRONT(1), .DEF_V_SYNC(2), .DEF_V_BACK(1),
    .DEF_HPOL(1'b0), .DEF_VPOL(1'b0)
  ) dut3 (
    .clk(clk), .rst(rst),
    .cfg_h_visible(chv), .cfg_h_front(chf),
    .cfg_h_sync(chs), .cfg_h_back(chb),
    .cfg_v_visible(cvv), .cfg_v_front(cvf),
    .cfg_v_sync(cvs), .cfg_v_back(cvb),
    .cfg_hpol(chp), .cfg_vpol(cvp), .cfg_valid(cval),
    .cfg_error(err3), .cfg_pending(pend3), .cfg_applied(appl3),
    .hsync(hs3), .vsync(vs3), .visible(vis3),
    .position_x(x3), .position_y(y3),
    .line_start(ls3), .frame_start(fs3), .frame(fr3)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int c      = 0;

  logic           r_hs0 [NR];
  logic           r_vs0 [NR];
  logic           r_vis0[NR];
  logic           r_ls0 [NR];
  logic           r_fs0 [NR];
  logic [H_W-1:0] r_x0  [NR];
  logic [V_W-1:0] r_y0  [NR];
  logic [FW-1:0]  r_fr0 [NR];
  logic           r_hs3 [NR];
  logic           r_vs3 [NR];
  logic           r_vis3[NR];
  logic           r_ls3 [NR];
  logic           r_fs3 [NR];
  logic [H_W-1:0] r_x3  [NR];
  logic [FW-1:0]  r_fr3 [NR];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    c++;
  endtask

  task automatic go(int t);
    while (c < t) tick();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    cval = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    c   = 0;
  endtask

  task automatic wr(int hv, int hf, int hs, int hb,
                    int vv, int vf, int vs, int vb,
                    bit hp, bit vp);
    chv  = H_W'(hv);
    chf  = H_W'(hf);
    chs  = H_W'(hs);
    chb  = H_W'(hb);
    cvv  = V_W'(vv);
    cvf  = V_W'(vf);
    cvs  = V_W'(vs);
    cvb  = V_W'(vb);
    chp  = hp;
    cvp  = vp;
    cval = 1'b1;
    tick();
    cval = 1'b0;
  endtask

  initial begin
    int nv0;
    int nv3;
    int nfs;
    chv = '0; chf = '0; chs = '0; chb = '0;
    cvv = '0; cvf = '0; cvs = '0; cvb = '0;
    chp = 1'b0; cvp = 1'b0; cval = 1'b0;

    // default small mode, both delays
    do_reset();
    for (int i = 0; i < NR; i++) begin
      r_hs0[i] = hs0;  r_vs0[i] = vs0;  r_vis0[i] = vis0;
      r_ls0[i] = ls0;  r_fs0[i] = fs0;  r_x0[i]   = x0;
      r_y0[i]  = y0;   r_fr0[i] = fr0;
      r_hs3[i] = hs3;  r_vs3[i] = vs3;  r_vis3[i] = vis3;
      r_ls3[i] = ls3;  r_fs3[i] = fs3;  r_x3[i]   = x3;
      r_fr3[i] = fr3;
      tick();
    end
    chk("rst_vis",   r_vis0[0], 1);
    chk("rst_fs",    r_fs0[0],  1);
    chk("rst_ls",    r_ls0[0],  1);
    chk("rst_frame", r_fr0[0],  0);
    chk("rst_hs",    r_hs0[0],  1);
    chk("rst_pend",  pend0 === 1'b0 && err0 === 1'b0, 1);
    chk("x_h3",      r_x0[3],   3);
    chk("vis_h8",    r_vis0[8], 0);
    chk("hs_h9",     r_hs0[9],  1);
    chk("hs_h10",    r_hs0[10], 0);
    chk("hs_h12",    r_hs0[12], 0);
    chk("hs_h13",    r_hs0[13], 1);
    chk("ls_v1",     r_ls0[15], 1);
    chk("y_v1",      r_y0[15],  1);
    chk("fs_v1",     r_fs0[15], 0);
    chk("vs_v4",     r_vs0[74], 1);
    chk("vs_v5",     r_vs0[75], 0);
    chk("vs_v6e",    r_vs0[104], 0);
    chk("vs_v7",     r_vs0[105], 1);
    chk("ls_v4",     r_ls0[60], 0);
    chk("fr_119",    r_fr0[119], 0);
    chk("fs_120",    r_fs0[120], 1);
    chk("fr_120",    r_fr0[120], 1);
    chk("fr_240",    r_fr0[240], 2);
    nv0 = 0;
    nv3 = 0;
    nfs = 0;
    for (int i = 0; i < 120; i++) nv0 += int'(r_vis0[i]);
    for (int i = 3; i < 123; i++) nv3 += int'(r_vis3[i]);
    for (int i = 0; i < 240; i++) nfs += int'(r_fs0[i]);
    chk("vis_cnt0", nv0, 32);
    chk("vis_cnt3", nv3, 32);
    chk("fs_cnt",   nfs, 2);
    for (int i = 0; i < 3; i++) begin
      chk("d3_rst_hs",  r_hs3[i],  1);
      chk("d3_rst_vs",  r_vs3[i],  1);
      chk("d3_rst_x",   r_x3[i],   0);
      chk("d3_rst_vis", r_vis3[i], 0);
      chk("d3_rst_fs",  r_fs3[i],  0);
    end
    chk("d3_fs3",    r_fs3[3],   1);
    chk("d3_ls3",    r_ls3[3],   1);
    chk("d3_x6",     r_x3[6],    3);
    chk("d3_hs12",   r_hs3[12],  1);
    chk("d3_hs13",   r_hs3[13],  0);
    chk("d3_hs15",   r_hs3[15],  0);
    chk("d3_hs16",   r_hs3[16],  1);
    chk("d3_ls18",   r_ls3[18],  1);
    chk("d3_vs77",   r_vs3[77],  1);
    chk("d3_vs78",   r_vs3[78],  0);
    chk("d3_fr122",  r_fr3[122], 0);
    chk("d3_fs123",  r_fs3[123], 1);
    chk("d3_fr123",  r_fr3[123], 1);

    // mid-frame write applied at the frame boundary
    do_reset();
    go(20);
    wr(6, 1, 1, 1, 3, 1, 1, 1, 1'b0, 1'b0);
    chk("t3_pend21", pend0, 1);
    chk("t3_err21",  err0,  0);
    go(118);
    chk("t3_pend118", pend0, 1);
    chk("t3_appl118", appl0, 0);
    go(119);
    chk("t3_pend119", pend0, 1);
    chk("t3_appl119", appl0, 1);
    go(120);
    chk("t3_pend120", pend0, 0);
    chk("t3_appl120", appl0, 0);
    chk("t3_fs120",   fs0,   1);
    chk("t3_fr120",   fr0,   1);
    go(127);
    chk("t3_hs127", hs0, 0);
    go(128);
    chk("t3_hs128", hs0, 1);
    go(129);
    chk("t3_ls129", ls0, 1);
    chk("t3_y129",  y0,  1);
    go(156);
    chk("t3_vs156", vs0, 0);
    go(165);
    chk("t3_vs165", vs0, 1);
    go(173);
    chk("t3_fs173", fs0, 0);
    go(174);
    chk("t3_fs174", fs0, 1);
    chk("t3_fr174", fr0, 2);

    // rejected writes leave shadow, pending and timing alone
    do_reset();
    go(5);
    wr(8, 2, 0, 2, 4, 1, 2, 1, 1'b0, 1'b0);
    chk("t4_err6",  err0,  1);
    chk("t4_pend6", pend0, 0);
    tick();
    chk("t4_err7",  err0,  0);
    wr(4000, 32, 32, 32, 4, 1, 2, 1, 1'b0, 1'b0);
    chk("t4_err_ht", err0,  1);
    chk("t4_pend8",  pend0, 0);
    wr(4000, 31, 32, 32, 4, 1, 2, 1, 1'b0, 1'b0);
    chk("t4_ok_ht",  err0,  0);
    chk("t4_pend9",  pend0, 1);
    wr(6, 1, 0, 1, 3, 1, 1, 1, 1'b0, 1'b0);
    chk("t4_err10",  err0,  1);
    chk("t4_pend10", pend0, 1);
    wr(8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0);
    chk("t4_pend11", pend0, 1);
    go(119);
    chk("t4_appl119", appl0, 1);
    go(120);
    chk("t4_fs120", fs0, 1);
    go(135);
    chk("t4_ls135", ls0, 1);

    // last write wins; write in the apply cycle
    do_reset();
    go(10);
    wr(6, 1, 1, 1, 3, 1, 1, 1, 1'b0, 1'b0);
    wr(4, 2, 2, 2, 2, 1, 1, 1, 1'b0, 1'b0);
    chk("t5_pend12", pend0, 1);
    go(119);
    chk("t5_appl119", appl0, 1);
    go(120);
    chk("t5_fs120",  fs0,   1);
    chk("t5_pend120", pend0, 0);
    go(123);
    chk("t5_x123",   x0,    3);
    go(124);
    chk("t5_vis124", vis0,  0);
    go(129);
    chk("t5_ls129",  ls0,   0);
    go(130);
    chk("t5_ls130",  ls0,   1);
    chk("t5_y130",   y0,    1);
    go(140);
    wr(6, 1, 1, 1, 3, 1, 1, 1, 1'b0, 1'b0);
    chk("t5_pend141", pend0, 1);
    go(169);
    chk("t5_appl169", appl0, 1);
    wr(8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0);
    chk("t5_pend170", pend0, 1);
    chk("t5_appl170", appl0, 0);
    chk("t5_fs170",   fs0,   1);
    chk("t5_fr170",   fr0,   2);
    go(178);
    chk("t5_ls178", ls0, 0);
    go(179);
    chk("t5_ls179", ls0, 1);
    go(223);
    chk("t5_appl223", appl0, 1);
    go(224);
    chk("t5_fs224",   fs0,   1);
    chk("t5_fr224",   fr0,   3);
    chk("t5_pend224", pend0, 0);
    go(238);
    chk("t5_ls238", ls0, 0);
    go(239);
    chk("t5_ls239", ls0, 1);

    // polarity change, then reset with a write pending
    do_reset();
    go(3);
    wr(8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b0);
    chk("t6_pend4", pend0, 1);
    go(120);
    chk("t6_fs120", fs0, 1);
    go(129);
    chk("t6_hs129", hs0, 0);
    go(130);
    chk("t6_hs130", hs0, 1);
    go(150);
    wr(6, 1, 1, 1, 3, 1, 1, 1, 1'b0, 1'b0);
    chk("t6_pend151", pend0, 1);
    go(160);
    chk("t6_fr160", fr0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    c = 0;
    chk("t6_rst_fs",   fs0,   1);
    chk("t6_rst_ls",   ls0,   1);
    chk("t6_rst_vis",  vis0,  1);
    chk("t6_rst_pend", pend0, 0);
    chk("t6_rst_fr",   fr0,   0);
    chk("t6_rst_x",    x0,    0);
    go(10);
    chk("t6_hs10", hs0, 0);
    go(13);
    chk("t6_hs13", hs0, 1);
    go(15);
    chk("t6_ls15", ls0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Runtime-programmable successor to the fixed-mode VGA timer. Generates hsync/vsync, visible, pixel coordinates, line/frame strobes and a frame counter. Timing is loaded through a shadowed config port and applied only at frame boundaries, so resolution changes are glitch-free. All timing outputs can be delayed by a fixed number of cycles to line up with a downstream pixel pipeline.

Parameters:
H_W, 12, width of horizontal field registers and counter
V_W, 11, width of vertical field registers and counter
FRAME_W, 32, frame counter width
DELAY, 0, pipeline stages added to all timing outputs (0..8)
DEF_H_VISIBLE/DEF_H_FRONT/DEF_H_SYNC/DEF_H_BACK, 640/16/96/48, reset horizontal timing
DEF_V_VISIBLE/DEF_V_FRONT/DEF_V_SYNC/DEF_V_BACK, 480/10/2/33, reset vertical timing
DEF_HPOL/DEF_VPOL, 0/0, reset sync polarity (0 = active-low)

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
cfg_h_visible, cfg_h_front, cfg_h_sync, cfg_h_back  in  H_W each  requested horizontal timing
cfg_v_visible, cfg_v_front, cfg_v_sync, cfg_v_back  in  V_W each  requested vertical timing (lines)
cfg_hpol, cfg_vpol  in  1  requested sync polarity (1 = active-high)
cfg_valid  in  1  one-cycle write strobe
cfg_error  out  1  one-cycle pulse: write rejected
cfg_pending  out  1  accepted config waiting for the frame boundary
cfg_applied  out  1  one-cycle pulse: shadow copied to the active set
hsync, vsync  out  1  sync outputs, polarity applied
visible  out  1  active video
position_x  out  H_W  pixel x; 0 when not visible
position_y  out  V_W  pixel y; 0 when not visible
line_start  out  1  pulse at x=0 of each visible line
frame_start  out  1  pulse at (0,0)
frame  out  FRAME_W  completed-frame count

Behaviour:
- Counters h (0..HT-1) and v (0..VT-1). HT = sum of the 4 h fields; VT likewise. Region order: visible, front, sync, back.
- visible = h<HV && v<VV.
- Sync active: h in [HV+HF, HV+HF+HS) and v in [VV+VF, VV+VF+VS). Vsync spans whole lines. Output = active XOR ~pol.
- h wraps at HT-1. v advances on h wrap and wraps at VT-1.
- line_start = h==0 && v<VV. frame_start = h==0 && v==0.
- frame increments on every (0,0) after the first one following reset. It updates in the same cycle as frame_start and wraps modulo 2^FRAME_W.
- Reset (any cycle, including mid-frame): h=v=0, active set = DEF_*, shadow cleared, cfg_pending=0, frame=0, all pulses 0.
- First cycle after rst deasserts: (0,0) with visible=1, frame_start=1, line_start=1, frame=0 (DELAY=0).
- Config write on cfg_valid: rejected with cfg_error the next cycle, shadow unchanged, if any field is 0 or if HT ≥ 2^H_W or VT ≥ 2^V_W. Sums are computed 2 bits wider. Otherwise the shadow is loaded and cfg_pending=1 the next cycle.
- Repeated writes while pending: last write wins.
- Apply: in the cycle with h==HT-1 && v==VT-1 and cfg_pending=1, the active set is loaded from the shadow, cfg_pending clears and cfg_applied pulses. The next cycle is (0,0) under the new timing.
- cfg_valid in the apply cycle: the old shadow is applied, the new write is captured, and cfg_pending stays 1.
- Delay stage: hsync, vsync, visible, position_x/y, line_start, frame_start and frame pass through DELAY registers. The cfg_* outputs are not delayed.
- Delay-register reset values: syncs at inactive level per DEF_*POL, all other delayed outputs 0.

Decomposition:
- Package video_timing_pkg: timing_cfg_t struct (8 fields plus 2 polarities), default-mode constant, validity-check function.
- One sub-module, video_delay_line: a parametrised DELAY-deep shift register with per-bit reset value, used for the output alignment.

Test Plan:
1. Small mode HV/HF/HS/HB=8/2/3/2, VV/VF/VS/VB=4/1/2/1, DELAY=0, after reset:
   - HT=15; hsync low at h=10..12.
   - vsync low on v=5..6.
   - frame_start every 120 cycles; frame reads 1 at the second frame_start.
   - visible for exactly 32 cycles per frame.
2. Same mode with DELAY=3: every delayed output equals the DELAY=0 run shifted by exactly 3 cycles; first 3 cycles after reset show inactive syncs and zero positions.
3. Write 6/1/1/1 x 3/1/1/1 mid-frame:
   - cfg_pending=1 until the last cycle of the current frame.
   - cfg_applied pulses at h=14, v=7.
   - Next frame has HT=9, VT=6.
4. Write with cfg_h_sync=0 → cfg_error pulse, cfg_pending unchanged, timing unchanged. Write with HT=4096 at H_W=12 → cfg_error.
5. Two writes (A then B) within one frame → only B applied. A write in the apply cycle → first write applied, cfg_pending stays 1, second write applied one frame later.
6. Assert rst mid-frame with cfg_pending=1 → next cycle (0,0), DEF timing, cfg_pending=0, frame=0; polarity cfg_hpol=1 after apply gives active-high hsync.
